// File: rtl/sum_uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// Package: sum_uart_pkg
// Purpose: Shared definitions for the sum-latch UART link. The transmitter and
//          the receiver both import this package, so they always agree on the
//          default bit period and the payload width.
// Contents:
//   UART_DATA_BITS    payload bits per frame (fixed at 8, no parity)
//   UART_CLKS_PER_BIT default clk cycles per bit (50 MHz / 115200)
//   rx_state_t        receiver FSM states
// -----------------------------------------------------------------------------
package sum_uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  // Receiver FSM states. BREAK exists so that a line held low after a bad
  // stop bit is not mistaken for a fresh start bit.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/sum_uart_rx_if.sv
// -----------------------------------------------------------------------------
// Interface: sum_uart_rx_if
// Purpose: Valid/ready byte handshake between the UART receiver (master) and
//          the board-side display/check logic (slave).
// Signals:
//   rx_data   received byte, stable while rx_valid is high
//   rx_valid  holding register full
//   rx_ready  consumer takes rx_data on a clock edge where valid&ready
// Modports:
//   master    drives rx_data/rx_valid, reads rx_ready
//   slave     reads rx_data/rx_valid, drives rx_ready
// -----------------------------------------------------------------------------
interface sum_uart_rx_if;
  import sum_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sum_uart_rx_sync2.sv
// -----------------------------------------------------------------------------
// Module: sum_uart_sync2
// Purpose: Two-flop synchronizer for the asynchronous serial line. Both flops
//          reset to 1 so that an idle (high) line is seen during and right after
//          reset, and no false start bit is produced.
// Ports:
//   clk       in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   i_async   in  asynchronous input
//   o_sync    out synchronized copy of i_async, two clocks late
// -----------------------------------------------------------------------------
module sum_uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_pipe;

  // Shift the raw line through two flops; only r_pipe[1] is safe to use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= 2'b11;
    end else begin
      r_pipe <= {r_pipe[0], i_async};
    end
  end

  assign o_sync = r_pipe[1];

endmodule

// File: rtl/sum_uart_rx.sv
// -----------------------------------------------------------------------------
// Module: sum_uart_rx
// Purpose: 8N1 UART receiver (LSB first, idle high) for the downstream end of
//          the sum-latch link. Received bytes go into a one-entry holding
//          register read through a valid/ready interface. Bad stop bits give a
//          frame_err pulse, and bytes that arrive while the register is still
//          full give an overrun pulse.
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit, must be >= 4
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset (deasserted synchronously inside)
//   uart_rxd   in   serial line, asynchronous to clk
//   rx_if      master side of the byte handshake (rx_data/rx_valid/rx_ready)
//   rx_busy    out  high from start-bit detection until the frame ends or aborts
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   overrun    out  1-cycle pulse, good frame while the holding register is full
// -----------------------------------------------------------------------------
module sum_uart_rx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          uart_rxd,
  sum_uart_rx_if.master rx_if,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overrun
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic [1:0]                r_rstPipe;
  logic                      w_rstN;
  logic                      w_rxdS;
  rx_state_t                 r_state;
  logic [BAUD_W-1:0]         r_baudCnt;
  logic [2:0]                r_bitCnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_frameErr;
  logic                      r_overrun;

  // Reset is asserted at once but released on a clock edge, so the whole
  // receiver leaves reset in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstPipe <= 2'b00;
    end else begin
      r_rstPipe <= {r_rstPipe[0], 1'b1};
    end
  end

  assign w_rstN = r_rstPipe[1];

  sum_uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (w_rstN),
    .i_async (uart_rxd),
    .o_sync  (w_rxdS)
  );

  // Receive FSM plus holding register. The START state waits half a bit so
  // that every later sample falls near the middle of a bit. Both counters are
  // cleared whenever a new state is entered. The holding-register handshake
  // is written first and can be overridden by a delivery in the same cycle.
  // That is how a byte read on the stop-sample edge is replaced by the new
  // byte without an overrun.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state    <= ST_IDLE;
      r_baudCnt  <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_rxdS) begin
            r_state   <= ST_START;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (r_baudCnt == HALF_LAST) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            if (w_rxdS) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt <= '0;
            r_shift   <= {w_rxdS, r_shift[UART_DATA_BITS-1:1]};
            if (r_bitCnt == LAST_BIT) begin
              r_state  <= ST_STOP;
              r_bitCnt <= '0;
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            if (w_rxdS) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              if (!r_valid || rx_if.rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_state    <= ST_BREAK;
              r_frameErr <= 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_BREAK: begin
          if (w_rxdS) begin
            r_state   <= ST_IDLE;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign rx_busy        = r_busy;
  assign frame_err      = r_frameErr;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_sum_uart_rx.sv
// -----------------------------------------------------------------------------
// Testbench: tb_sum_uart_rx
// Purpose: Drives 8N1 frames into sum_uart_rx with CLKS_PER_BIT=16. A consumer
//          monitor records every byte taken through the handshake and counts
//          error pulses. Each scenario task works out its expected bytes and
//          pulse counts from the link rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sum_uart_rx;
  import sum_uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic rx_busy, frame_err, overrun;

  sum_uart_rx_if rxIf ();

  sum_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rxd  (uart_rxd),
    .rx_if     (rxIf),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] acceptedQ[$];
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int validCycles = 0;

  // Consumer-side monitor, sampled mid-cycle. valid&ready seen here means the
  // byte is taken at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err) frameErrCnt++;
      if (overrun) overrunCnt++;
      if (rxIf.rx_valid) validCycles++;
      if (rxIf.rx_valid && rxIf.rx_ready) acceptedQ.push_back(rxIf.rx_data);
    end
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearMonitor();
    acceptedQ.delete();
    frameErrCnt = 0;
    overrunCnt = 0;
    validCycles = 0;
  endtask

  // Drives one 10-bit frame. Cycle c is driven just after rising edge c.
  // readyEdge >= 0 raises rx_ready only for that edge.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                           input int readyEdge, output int firstValid);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    firstValid = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      uart_rxd = bits[c / CPB];
      if (readyEdge >= 0) rxIf.rx_ready = (c == readyEdge - 1);
      if (rxIf.rx_valid && firstValid < 0) firstValid = c;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    uart_rxd = 1'b1;
    rxIf.rx_ready = 1'b0;
    tick(3);
    total++; if (rxIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", rxIf.rx_valid); end
    total++; if (rxIf.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", rxIf.rx_data); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", rx_busy); end
    total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("[TB] FAIL reset_pulses: got %b want 00", {frame_err, overrun}); end
    reset_n = 1'b1;
    tick(6);
    total++; if ({rxIf.rx_valid, rx_busy} !== 2'b00) begin bad++; $display("[TB] FAIL reset_release: got %b want 00", {rxIf.rx_valid, rx_busy}); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    int fv;
    rxIf.rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'hA5 : 8'($urandom);
      clearMonitor();
      sendFrame(b, 1'b1, -1, fv);
      tick(4);
      total++; if (acceptedQ.size() != 1 || acceptedQ[0] !== b) begin bad++; $display("[TB] FAIL single_data: got n=%0d first=%h want n=1 %h", acceptedQ.size(), (acceptedQ.size() > 0) ? acceptedQ[0] : 8'hxx, b); end
      total++; if (validCycles != 1) begin bad++; $display("[TB] FAIL single_valid_len: got %0d want 1", validCycles); end
      total++; if (frameErrCnt != 0 || overrunCnt != 0) begin bad++; $display("[TB] FAIL single_pulses: got ferr=%0d ovr=%0d want 0 0", frameErrCnt, overrunCnt); end
      total++; if (fv < LAT - 1 || fv > LAT + 1) begin bad++; $display("[TB] FAIL single_latency: got %0d want %0d+/-1", fv, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int n;
    int fv;
    int waitCnt;
    n = 2 + $urandom_range(0, 2);
    rxIf.rx_ready = 1'b0;
    clearMonitor();
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? 8'h3C : (i == 1) ? 8'h0F : 8'($urandom);
      sendFrame(b, 1'b1, -1, fv);
    end
    tick(4);
    total++; if (rxIf.rx_valid !== 1'b1 || rxIf.rx_data !== 8'h3C) begin bad++; $display("[TB] FAIL b2b_held: got v=%b d=%h want v=1 d=3c", rxIf.rx_valid, rxIf.rx_data); end
    total++; if (overrunCnt != n - 1) begin bad++; $display("[TB] FAIL b2b_overrun: got %0d want %0d", overrunCnt, n - 1); end
    total++; if (acceptedQ.size() != 0) begin bad++; $display("[TB] FAIL b2b_early_accept: got %0d want 0", acceptedQ.size()); end
    rxIf.rx_ready = 1'b1;
    waitCnt = 0;
    while (rxIf.rx_valid && waitCnt < 10) begin
      tick(1);
      waitCnt++;
    end
    total++; if (rxIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got valid=%b want 0 within 10 cycles", rxIf.rx_valid); end
    total++; if (acceptedQ.size() != 1 || acceptedQ[0] !== 8'h3C) begin bad++; $display("[TB] FAIL b2b_accepted: got n=%0d want 1 byte 3c", acceptedQ.size()); end
  endtask

  task automatic test_false_start();
    int glitch;
    logic sawBusy;
    rxIf.rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      glitch = (i == 0) ? 4 : $urandom_range(1, 4);
      clearMonitor();
      sawBusy = 1'b0;
      uart_rxd = 1'b0;
      tick(glitch);
      uart_rxd = 1'b1;
      for (int c = 0; c < 3 * CPB; c++) begin
        tick(1);
        if (rx_busy) sawBusy = 1'b1;
      end
      total++; if (sawBusy !== 1'b1 || rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL false_start_busy: got seen=%b now=%b want 1 0", sawBusy, rx_busy); end
      total++; if (validCycles != 0 || frameErrCnt != 0) begin bad++; $display("[TB] FAIL false_start_out: got valid=%0d ferr=%0d want 0 0", validCycles, frameErrCnt); end
    end
  endtask

  task automatic test_frame_error();
    int fv;
    rxIf.rx_ready = 1'b1;
    clearMonitor();
    sendFrame(8'h55, 1'b0, -1, fv);
    tick(2 * CPB);
    total++; if (frameErrCnt != 1) begin bad++; $display("[TB] FAIL ferr_count: got %0d want 1", frameErrCnt); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("[TB] FAIL ferr_break_busy: got %b want 1", rx_busy); end
    uart_rxd = 1'b1;
    tick(CPB);
    total++; if (rx_busy !== 1'b0 || frameErrCnt != 1 || validCycles != 0) begin bad++; $display("[TB] FAIL ferr_recover: got busy=%b ferr=%0d valid=%0d want 0 1 0", rx_busy, frameErrCnt, validCycles); end
    clearMonitor();
    sendFrame(8'h12, 1'b1, -1, fv);
    tick(4);
    total++; if (acceptedQ.size() != 1 || acceptedQ[0] !== 8'h12 || frameErrCnt != 0) begin bad++; $display("[TB] FAIL ferr_next_frame: got n=%0d ferr=%0d want 1 byte 12 ferr 0", acceptedQ.size(), frameErrCnt); end
  endtask

  task automatic test_simultaneous();
    int fv;
    rxIf.rx_ready = 1'b0;
    clearMonitor();
    sendFrame(8'h01, 1'b1, -1, fv);
    sendFrame(8'h02, 1'b1, LAT, fv);
    tick(3);
    total++; if (overrunCnt != 0) begin bad++; $display("[TB] FAIL simul_overrun: got %0d want 0", overrunCnt); end
    total++; if (rxIf.rx_valid !== 1'b1 || rxIf.rx_data !== 8'h02) begin bad++; $display("[TB] FAIL simul_hold: got v=%b d=%h want v=1 d=02", rxIf.rx_valid, rxIf.rx_data); end
    total++; if (acceptedQ.size() != 1 || acceptedQ[0] !== 8'h01) begin bad++; $display("[TB] FAIL simul_first: got n=%0d want 1 byte 01", acceptedQ.size()); end
    rxIf.rx_ready = 1'b1;
    tick(3);
    total++; if (acceptedQ.size() != 2 || acceptedQ[1] !== 8'h02 || rxIf.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL simul_drain: got n=%0d v=%b want 2 bytes v=0", acceptedQ.size(), rxIf.rx_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    logic [7:0] b;
    int fv;
    rxIf.rx_ready = 1'b1;
    clearMonitor();
    bits = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 4 * CPB; c++) begin
      tick(1);
      uart_rxd = bits[c / CPB];
    end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy_before: got %b want 1", rx_busy); end
    reset_n = 1'b0;
    #1;
    total++; if ({rxIf.rx_valid, rx_busy, frame_err, overrun} !== 4'b0000 || rxIf.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL midrst_outputs: got v=%b b=%b fe=%b ov=%b d=%h want all 0", rxIf.rx_valid, rx_busy, frame_err, overrun, rxIf.rx_data); end
    uart_rxd = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(2 * CPB);
    total++; if (frameErrCnt != 0 || overrunCnt != 0 || validCycles != 0) begin bad++; $display("[TB] FAIL midrst_silent: got ferr=%0d ovr=%0d valid=%0d want 0 0 0", frameErrCnt, overrunCnt, validCycles); end
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'h81 : 8'($urandom);
      clearMonitor();
      sendFrame(b, 1'b1, -1, fv);
      tick(4);
      total++; if (acceptedQ.size() != 1 || acceptedQ[0] !== b) begin bad++; $display("[TB] FAIL midrst_next_frame: got n=%0d want 1 byte %h", acceptedQ.size(), b); end
    end
  endtask

  initial begin
    rxIf.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_simultaneous();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
